uart_baud_gen: RTL and testbench

Parametrised baud/sample-tick generator for the UART TX and RX paths. It replaces the fixed single-pulse bit timer. The divisor is programmable at run time, and the block produces oversample ticks, a mid-bit sample strobe for RX, an end-of-bit strobe for TX/RX shifting, and frame-level bit counting with a frame-done strobe. It sits between the register/config logic and the UART shift-register FSMs.

---
 rtl/uart_baud_gen_pkg.sv | 13 +
 rtl/uart_baud_gen_prescaler.sv | 34 +++
 rtl/uart_baud_gen.sv | 96 +++++++++
 tb/tb_uart_baud_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_baud_gen_pkg.sv
// Shared types and default sizes for the UART baud/sample-tick generator.
package DataTypes;

   localparam int UART_OVERSAMPLE_DEFAULT = 16;
   localparam int UART_DIV_W_DEFAULT      = 16;
   localparam int UART_FRAME_W_DEFAULT    = 4;

   typedef logic                                       bit_t;
   typedef logic [UART_DIV_W_DEFAULT-1:0]              uart_div_t;
   typedef logic [$clog2(UART_OVERSAMPLE_DEFAULT)-1:0] uart_os_cnt_t;
   typedef logic [UART_FRAME_W_DEFAULT-1:0]            uart_frame_cnt_t;

endpackage

// File: rtl/uart_baud_gen_prescaler.sv
// Divide-by-div clock prescaler: pulses os_event combinationally on the last
// clock of each oversample period; sync clear realigns the phase.
module uart_prescaler
   import DataTypes::*;
#(
   parameter int DIV_W = UART_DIV_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  bit_t             enable,
   input  bit_t             clear,
   input  logic [DIV_W-1:0] div,
   output bit_t             os_event
);

   logic [DIV_W-1:0] pre_cnt;
   bit_t             at_end;
   bit_t             running;

   assign running  = enable && (div != '0);
   assign at_end   = (pre_cnt == div - DIV_W'(1));
   assign os_event = running && !clear && at_end;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_cnt <= '0;
      end else if (clear) begin
         pre_cnt <= '0;
      end else if (running) begin
         pre_cnt <= at_end ? '0 : pre_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_baud_gen.sv
// Programmable baud generator: oversample, mid-bit, end-of-bit and frame-done
// ticks with a bit index; divisor and frame length are shadowed per bit/frame.
module uart_baud_gen
   import DataTypes::*;
#(
   parameter int DIV_W      = UART_DIV_W_DEFAULT,
   parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT,
   parameter int FRAME_W    = UART_FRAME_W_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  bit_t               enable,
   input  bit_t               restart,
   input  logic [DIV_W-1:0]   divisor,
   input  logic [FRAME_W-1:0] frame_bits,
   output bit_t               os_tick,
   output bit_t               mid_tick,
   output bit_t               bit_tick,
   output bit_t               frame_done,
   output logic [FRAME_W-1:0] bit_index,
   output bit_t               cfg_err
);

   localparam int               OS_W    = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);

   logic [DIV_W-1:0]   div_q;
   logic [FRAME_W-1:0] fbits_q;
   logic [OS_W-1:0]    os_cnt;
   bit_t               os_event;
   bit_t               bit_event;
   bit_t               frame_end;

   uart_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .clear    (restart),
      .div      (div_q),
      .os_event (os_event)
   );

   assign bit_event = os_event && (os_cnt == OS_LAST);
   // A zero frame length never matches, so bit_index free-runs and frame_done stays low
   assign frame_end = bit_event && (fbits_q != '0) &&
                      (bit_index == fbits_q - FRAME_W'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q      <= '0;
         fbits_q    <= '0;
         os_cnt     <= '0;
         bit_index  <= '0;
         os_tick    <= 1'b0;
         mid_tick   <= 1'b0;
         bit_tick   <= 1'b0;
         frame_done <= 1'b0;
         cfg_err    <= 1'b1;
      end else begin
         os_tick    <= 1'b0;
         mid_tick   <= 1'b0;
         bit_tick   <= 1'b0;
         frame_done <= 1'b0;
         if (restart) begin
            os_cnt    <= '0;
            bit_index <= '0;
            div_q     <= divisor;
            fbits_q   <= frame_bits;
            cfg_err   <= (divisor == '0);
         end else if (os_event) begin
            os_tick  <= 1'b1;
            mid_tick <= (os_cnt == OS_MID);
            if (bit_event) begin
               // Rate changes are only picked up on bit boundaries
               os_cnt   <= '0;
               bit_tick <= 1'b1;
               div_q    <= divisor;
               cfg_err  <= (divisor == '0);
               if (frame_end) begin
                  bit_index  <= '0;
                  frame_done <= 1'b1;
                  fbits_q    <= frame_bits;
               end else begin
                  bit_index <= bit_index + FRAME_W'(1);
               end
            end else begin
               os_cnt <= os_cnt + OS_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: tick times are derived arithmetically
// per bit and checked cycle by cycle by an independent monitor.
module tb_uart_baud_gen;
   import DataTypes::*;

   localparam int DIV_W   = 16;
   localparam int OS      = 16;
   localparam int FRAME_W = 4;

   logic               clk        = 1'b0;
   logic               reset      = 1'b0;
   logic               enable     = 1'b0;
   logic               restart    = 1'b0;
   logic [DIV_W-1:0]   divisor    = '0;
   logic [FRAME_W-1:0] frame_bits = '0;
   logic               os_tick, mid_tick, bit_tick, frame_done, cfg_err;
   logic [FRAME_W-1:0] bit_index;

   int cyc      = 0;
   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int at;
      int fd;
      int idx;
   } bit_exp_t;

   int       os_q[$];
   int       mid_q[$];
   bit_exp_t bit_q[$];
   bit_exp_t mon_e;

   uart_baud_gen #(
      .DIV_W      (DIV_W),
      .OVERSAMPLE (OS),
      .FRAME_W    (FRAME_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .restart    (restart),
      .divisor    (divisor),
      .frame_bits (frame_bits),
      .os_tick    (os_tick),
      .mid_tick   (mid_tick),
      .bit_tick   (bit_tick),
      .frame_done (frame_done),
      .bit_index  (bit_index),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Cycle on which the a-th enabled edge after restart lands, given a pause of
   // pl disabled edges inserted after the pa-th enabled edge.
   function automatic int ev_cycle(input int e0, input int a, input int pa, input int pl);
      return (a <= pa) ? e0 + a : e0 + a + pl;
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         if (os_q.size() > 0 && os_q[0] == cyc) begin
            chk("os_tick_expected", int'(os_tick), 1);
            void'(os_q.pop_front());
         end else begin
            chk("os_tick_idle", int'(os_tick), 0);
         end
         if (mid_q.size() > 0 && mid_q[0] == cyc) begin
            chk("mid_tick_expected", int'(mid_tick), 1);
            void'(mid_q.pop_front());
         end else begin
            chk("mid_tick_idle", int'(mid_tick), 0);
         end
         if (bit_q.size() > 0 && bit_q[0].at == cyc) begin
            mon_e = bit_q.pop_front();
            chk("bit_tick_expected", int'(bit_tick), 1);
            chk("frame_done_at_bit", int'(frame_done), mon_e.fd);
            chk("bit_index_at_bit", int'(bit_index), mon_e.idx);
            $display("bit_tick cycle %0d: bit_index %0d frame_done %0d", cyc, bit_index, frame_done);
         end else begin
            chk("bit_tick_idle", int'(bit_tick), 0);
            chk("frame_done_idle", int'(frame_done), 0);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_os_tick"}, int'(os_tick), 0);
      chk({tag, "_mid_tick"}, int'(mid_tick), 0);
      chk({tag, "_bit_tick"}, int'(bit_tick), 0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
      chk({tag, "_bit_index"}, int'(bit_index), 0);
      chk({tag, "_cfg_err"}, int'(cfg_err), 1);
   endtask

   task automatic run_segment(input int d0, input int d1, input int fb, input int nb,
                              input int pa, input int pl, input int abort_at);
      int       e0, s, d, last, n;
      bit_exp_t e;
      @(posedge clk); #1;
      restart    = 1'b1;
      enable     = 1'b1;
      divisor    = DIV_W'(d0);
      frame_bits = FRAME_W'(fb);
      e0 = cyc + 1;
      s  = 0;
      for (int b = 0; b < nb; b++) begin
         d = (b == 0) ? d0 : d1;
         for (int k = 1; k <= OS; k++) os_q.push_back(ev_cycle(e0, s + k * d, pa, pl));
         mid_q.push_back(ev_cycle(e0, s + (OS / 2) * d, pa, pl));
         e.at  = ev_cycle(e0, s + OS * d, pa, pl);
         e.fd  = (fb != 0 && (b + 1) % fb == 0) ? 1 : 0;
         e.idx = (fb != 0) ? (b + 1) % fb : (b + 1) % (1 << FRAME_W);
         bit_q.push_back(e);
         s += OS * d;
      end
      last = e0 + s + pl;
      $display("segment: divisor %0d->%0d frame_bits %0d bits %0d pause %0d after %0d, restart edge %0d",
               d0, d1, fb, nb, pl, pa, e0);
      while (cyc < last + 3) begin
         @(posedge clk); #1;
         restart = 1'b0;
         if (cyc == e0 + 1) chk("cfg_err_after_restart", int'(cfg_err), 0);
         if (abort_at != 0 && cyc == e0 + abort_at) begin
            reset = 1'b0;
            #1;
            check_reset_outputs("async_reset");
            os_q.delete();
            mid_q.delete();
            bit_q.delete();
            repeat (3) @(posedge clk);
            #1 reset = 1'b1;
            repeat (100) @(posedge clk);
            #1 chk("cfg_err_after_reset_release", int'(cfg_err), 1);
            $display("async reset at cycle %0d, 100 idle cycles after release", e0 + abort_at);
            return;
         end
         n = cyc + 1;
         enable = !((n > e0 + pa && n <= e0 + pa + pl) || n > last);
         if (n >= e0 + 5) divisor = DIV_W'(d1);
      end
      chk("os_queue_drained", os_q.size(), 0);
      chk("mid_queue_drained", mid_q.size(), 0);
      chk("bit_queue_drained", bit_q.size(), 0);
   endtask

   task automatic run_zero_div();
      @(posedge clk); #1;
      restart    = 1'b1;
      enable     = 1'b1;
      divisor    = '0;
      frame_bits = FRAME_W'(8);
      @(posedge clk); #1;
      restart = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         if (i % 100 == 0) chk("cfg_err_zero_divisor", int'(cfg_err), 1);
      end
      $display("zero divisor: 1000 cycles enabled");
   endtask

   initial begin
      int d0, d1, fb, nb, tot, pa, pl;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      reset  = 1'b1;
      enable = 1'b1;
      repeat (20) @(posedge clk);
      #1 chk("cfg_err_before_restart", int'(cfg_err), 1);

      run_segment(4, 4, 10, 10, 0, 0, 0);
      run_segment(1, 1, 5, 6, 0, 0, 0);
      run_segment(4, 2, 10, 3, 0, 0, 0);
      run_segment(4, 4, 10, 3, 40, 7, 0);
      run_zero_div();
      run_segment(3, 3, 4, 4, 0, 0, 0);
      run_segment(2, 2, 0, 18, 0, 0, 0);

      for (int r = 0; r < 6; r++) begin
         d0  = $urandom_range(1, 6);
         d1  = $urandom_range(1, 6);
         fb  = $urandom_range(0, 7);
         nb  = $urandom_range(2, 10);
         tot = OS * (d0 + (nb - 1) * d1);
         pa  = $urandom_range(1, tot - 1);
         pl  = $urandom_range(0, 9);
         run_segment(d0, d1, fb, nb, pa, pl, 0);
      end

      run_segment(1, 1, 8, 20, 0, 0, 100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
